// File: rtl/ping_pong_shifter.sv
// One-hot position register that sweeps LSB->MSB->LSB with a programmable dwell at each end.
// Optional MSB-end dwell is compiled in with `define PING_PONG_HI_DWELL_EN.
module ping_pong_shifter #(
  parameter int WIDTH    = 8,
  parameter int DWELL_LO = 3,
  parameter int DWELL_HI = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             dwell,
  output logic             wrap
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("ping_pong_shifter: WIDTH must be 2..32");
  end
  if (DWELL_LO < 0 || DWELL_LO > 255) begin : g_bad_dwell_lo
    $error("ping_pong_shifter: DWELL_LO must be 0..255");
  end
  if (DWELL_HI < 0 || DWELL_HI > 255) begin : g_bad_dwell_hi
    $error("ping_pong_shifter: DWELL_HI must be 0..255");
  end

  typedef enum logic [1:0] {
    ST_DWELL_LO = 2'd0,
    ST_SHIFT_UP = 2'd1,
`ifdef PING_PONG_HI_DWELL_EN
    ST_DWELL_HI = 2'd2,
`endif
    ST_SHIFT_DN = 2'd3
  } state_t;

  localparam logic [7:0]       DWELL_LO_C = DWELL_LO[7:0];
  localparam logic [WIDTH-1:0] ONE        = {{(WIDTH-1){1'b0}}, 1'b1};
`ifdef PING_PONG_HI_DWELL_EN
  localparam logic [7:0]       DWELL_HI_C = DWELL_HI[7:0];
`endif

  state_t           state, state_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic [WIDTH-1:0] count_shl, count_shr;
  logic [7:0]       dcnt, dcnt_nxt;
  logic             wrap_nxt;
  state_t           up_end;

  assign count_shl = {count[WIDTH-2:0], 1'b0};
  assign count_shr = {1'b0, count[WIDTH-1:1]};

  // State reached once the bit lands on the MSB.
`ifdef PING_PONG_HI_DWELL_EN
  assign up_end = (DWELL_HI > 0) ? ST_DWELL_HI : ST_SHIFT_DN;
`else
  assign up_end = ST_SHIFT_DN;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_DWELL_LO;
      count <= ONE;
      dcnt  <= 8'd0;
      wrap  <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      dcnt  <= dcnt_nxt;
      wrap  <= wrap_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    dcnt_nxt  = dcnt;
    wrap_nxt  = 1'b0;
    if (clr) begin
      state_nxt = ST_DWELL_LO;
      count_nxt = ONE;
      dcnt_nxt  = 8'd0;
    end else if (en) begin
      case (state)
        ST_DWELL_LO: begin
          // Counter saturates at DWELL_LO; the edge after that performs the shift.
          if (dcnt == DWELL_LO_C) begin
            count_nxt = count_shl;
            dcnt_nxt  = 8'd0;
            state_nxt = count_shl[WIDTH-1] ? up_end : ST_SHIFT_UP;
          end else begin
            dcnt_nxt = dcnt + 8'd1;
          end
        end
        ST_SHIFT_UP: begin
          count_nxt = count_shl;
          if (count_shl[WIDTH-1]) begin
            state_nxt = up_end;
            dcnt_nxt  = 8'd0;
          end
        end
`ifdef PING_PONG_HI_DWELL_EN
        ST_DWELL_HI: begin
          if (dcnt == DWELL_HI_C) begin
            count_nxt = count_shr;
            dcnt_nxt  = 8'd0;
            if (count_shr[0]) begin
              state_nxt = ST_DWELL_LO;
              wrap_nxt  = 1'b1;
            end else begin
              state_nxt = ST_SHIFT_DN;
            end
          end else begin
            dcnt_nxt = dcnt + 8'd1;
          end
        end
`endif
        ST_SHIFT_DN: begin
          count_nxt = count_shr;
          if (count_shr[0]) begin
            state_nxt = ST_DWELL_LO;
            dcnt_nxt  = 8'd0;
            wrap_nxt  = 1'b1;
          end
        end
        default: begin
          state_nxt = ST_DWELL_LO;
          count_nxt = ONE;
          dcnt_nxt  = 8'd0;
        end
      endcase
    end
  end

  always_comb begin
    dir   = 1'b0;
    dwell = 1'b0;
    case (state)
      ST_DWELL_LO: begin
        dir   = 1'b1;
        dwell = 1'b1;
      end
      ST_SHIFT_UP: dir = 1'b1;
`ifdef PING_PONG_HI_DWELL_EN
      ST_DWELL_HI: dwell = 1'b1;
`endif
      default: begin
        dir   = 1'b0;
        dwell = 1'b0;
      end
    endcase
  end

  a_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot(count));
  a_wrap_at_lsb: assert property (@(posedge clk) disable iff (!reset)
    wrap |-> (count == ONE && state == ST_DWELL_LO));

endmodule

// File: tb/tb_ping_pong_shifter.sv
// Scoreboarded bench: two instances (8-bit/dwell 3 and 4-bit/dwell 0) against a phase-based position model.
module tb_ping_pong_shifter;

  localparam int WA  = 8;
  localparam int DLA = 3;
  localparam int DHA = 2;
  localparam int WB  = 4;
  localparam int DLB = 0;
  localparam int DHB = 1;
`ifdef PING_PONG_HI_DWELL_EN
  localparam int DHA_E = DHA;
  localparam int DHB_E = DHB;
`else
  localparam int DHA_E = 0;
  localparam int DHB_E = 0;
`endif

  typedef struct packed {
    logic [31:0] count;
    logic        dir;
    logic        dwell;
    logic        wrap;
  } exp_t;

  logic          clk;
  logic          reset;
  logic          en;
  logic          clr;
  logic [WA-1:0] count_a;
  logic          dir_a, dwell_a, wrap_a;
  logic [WB-1:0] count_b;
  logic          dir_b, dwell_b, wrap_b;

  int   checks = 0;
  int   errors = 0;
  int   k_a = 0;
  int   k_b = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  ping_pong_shifter #(.WIDTH(WA), .DWELL_LO(DLA), .DWELL_HI(DHA)) u_dut_a (
    .clk(clk), .reset(reset), .en(en), .clr(clr),
    .count(count_a), .dir(dir_a), .dwell(dwell_a), .wrap(wrap_a)
  );

  ping_pong_shifter #(.WIDTH(WB), .DWELL_LO(DLB), .DWELL_HI(DHB)) u_dut_b (
    .clk(clk), .reset(reset), .en(en), .clr(clr),
    .count(count_b), .dir(dir_b), .dwell(dwell_b), .wrap(wrap_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int period(input int w, input int dl, input int dh);
    return 2 * (w - 1) + dl + dh;
  endfunction

  // Expected outputs after k enabled edges into a period.
  function automatic exp_t model(input int k, input int w, input int dl, input int dh, input logic wr);
    exp_t e;
    int   top;
    int   pos;
    e   = '0;
    top = dl + w - 1;
    if (k <= dl) begin
      pos = 0; e.dir = 1'b1; e.dwell = 1'b1;
    end else if (k < top) begin
      pos = k - dl; e.dir = 1'b1; e.dwell = 1'b0;
    end else if (k <= top + dh) begin
      pos = w - 1; e.dir = 1'b0; e.dwell = (dh > 0);
    end else begin
      pos = w - 1 - (k - top - dh); e.dir = 1'b0; e.dwell = 1'b0;
    end
    e.count = 32'd1 << pos;
    e.wrap  = wr;
    return e;
  endfunction

  task automatic advance(inout int k, output logic wr, input int p, input logic e, input logic c);
    wr = 1'b0;
    if (c) begin
      k = 0;
    end else if (e) begin
      k = k + 1;
      if (k == p) begin
        k  = 0;
        wr = 1'b1;
      end
    end
  endtask

  task automatic step(input logic e, input logic c);
    exp_t xa, xb;
    logic wr;
    @(negedge clk);
    en  = e;
    clr = c;
    advance(k_a, wr, period(WA, DLA, DHA_E), e, c);
    q_a.push_back(model(k_a, WA, DLA, DHA_E, wr));
    advance(k_b, wr, period(WB, DLB, DHB_E), e, c);
    q_b.push_back(model(k_b, WB, DLB, DHB_E, wr));
    @(posedge clk);
    #1;
    xa = q_a.pop_front();
    xb = q_b.pop_front();
    chk("count_a", 32'(count_a), xa.count);
    chk("dir_a",   32'(dir_a),   32'(xa.dir));
    chk("dwell_a", 32'(dwell_a), 32'(xa.dwell));
    chk("wrap_a",  32'(wrap_a),  32'(xa.wrap));
    chk("count_b", 32'(count_b), xb.count);
    chk("dir_b",   32'(dir_b),   32'(xb.dir));
    chk("dwell_b", 32'(dwell_b), 32'(xb.dwell));
    chk("wrap_b",  32'(wrap_b),  32'(xb.wrap));
  endtask

  initial begin
    int guard;
    en    = 1'b0;
    clr   = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    chk("rst_count_a", 32'(count_a), 32'h1);
    chk("rst_dir_a",   32'(dir_a),   32'h1);
    chk("rst_dwell_a", 32'(dwell_a), 32'h1);
    chk("rst_wrap_a",  32'(wrap_a),  32'h0);
    chk("rst_count_b", 32'(count_b), 32'h1);
    @(negedge clk);
    reset = 1'b1;

    // Free run over several full periods of both instances.
    repeat (45) step(1'b1, 1'b0);

    // Freeze mid-rise at 0x08, then resume.
    guard = 0;
    while (guard < 60 && !(count_a == 8'h08 && dir_a == 1'b1)) begin
      step(1'b1, 1'b0);
      guard++;
    end
    chk("reach_0x08", 32'(count_a), 32'h08);
    repeat (5) step(1'b0, 1'b0);
    repeat (20) step(1'b1, 1'b0);

    // Synchronous clear on the way down at 0x10, with en high and then en low.
    guard = 0;
    while (guard < 60 && !(count_a == 8'h10 && dir_a == 1'b0)) begin
      step(1'b1, 1'b0);
      guard++;
    end
    chk("reach_0x10", 32'(count_a), 32'h10);
    step(1'b1, 1'b1);
    repeat (5) step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    repeat (10) step(1'b1, 1'b0);

    // Random enable and occasional clear.
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
    end

    // Asynchronous reset on the way down at 0x20, observed before the next clock edge.
    guard = 0;
    while (guard < 60 && !(count_a == 8'h20 && dir_a == 1'b0)) begin
      step(1'b1, 1'b0);
      guard++;
    end
    chk("reach_0x20", 32'(count_a), 32'h20);
    en  = 1'b0;
    clr = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("arst_count_a", 32'(count_a), 32'h1);
    chk("arst_dir_a",   32'(dir_a),   32'h1);
    chk("arst_dwell_a", 32'(dwell_a), 32'h1);
    chk("arst_wrap_a",  32'(wrap_a),  32'h0);
    chk("arst_count_b", 32'(count_b), 32'h1);
    k_a = 0;
    k_b = 0;
    @(negedge clk);
    reset = 1'b1;
    repeat (25) step(1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ping_pong_shifter.md
PING_PONG_SHIFTER -- requirements
Module: ping_pong_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, one-hot register width, legal range 2..32.
REQ-002 SHALL have parameter DWELL_LO, default 3, enabled edges held at LSB end, legal range 0..255.
REQ-003 SHALL have parameter DWELL_HI, default 3, enabled edges held at MSB end, legal range 0..255; used only under PING_PONG_HI_DWELL_EN.
REQ-004 SHALL have port clk, input, 1, sole clock, rising-edge active.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port en, input, 1, advance enable; when low, all state holds.
REQ-007 SHALL have port clr, input, 1, synchronous clear to reset state; takes priority over en.
REQ-008 SHALL have port count, output, WIDTH, one-hot position register.
REQ-009 SHALL have port dir, output, 1, 1 = moving/dwelling toward MSB, 0 = moving toward LSB.
REQ-010 SHALL have port dwell, output, 1, high while in a dwell state.
REQ-011 SHALL have port wrap, output, 1, registered single-cycle pulse on completion of a full period.

Function
REQ-012 SHALL implement a state machine with states DWELL_LO, SHIFT_UP, DWELL_HI, SHIFT_DN, all updated only on rising clk with en=1.
REQ-013 DWELL_LO SHALL hold count=1 for exactly DWELL_LO enabled edges, then go to SHIFT_UP with the next enabled edge performing the first left shift; DWELL_LO=0 SHALL shift on the first enabled edge.
REQ-014 SHIFT_UP SHALL shift count left by one per enabled edge; on the edge that sets bit WIDTH-1, next state SHALL be DWELL_HI (macro defined, DWELL_HI>0) or SHIFT_DN otherwise.
REQ-015 DWELL_HI SHALL hold count at MSB for exactly DWELL_HI enabled edges, then enter SHIFT_DN.
REQ-016 SHIFT_DN SHALL shift count right by one per enabled edge; on the edge that sets bit 0, next state SHALL be DWELL_LO with dwell counter zeroed, and wrap SHALL be high for the following cycle only.
REQ-017 count SHALL remain exactly one-hot at all times; no shift SHALL ever move the bit out of range.
REQ-018 Period without MSB dwell SHALL be 2*(WIDTH-1)+DWELL_LO enabled edges; with it, add DWELL_HI.
REQ-019 dir SHALL be 1 in DWELL_LO and SHIFT_UP, 0 in DWELL_HI and SHIFT_DN; dwell SHALL be 1 in DWELL_LO and DWELL_HI only.
REQ-020 Dwell counter SHALL be 8 bits, SHALL clear on every dwell-state entry, and SHALL never wrap.
REQ-021 en=0 SHALL freeze state, count and dwell counter; wrap SHALL be 0 in any cycle where en was 0 on the prior edge.
REQ-022 clr=1 on an edge SHALL load the reset state regardless of en or current state; wrap SHALL be 0 next cycle.
REQ-023 All state SHALL reside in one clock domain; no logic SHALL be clocked by count bits or any derived signal.

Reset
REQ-024 reset low SHALL immediately force count=1, state DWELL_LO, dwell counter 0, dir=1, dwell=1, wrap=0.
REQ-025 Reset asserted mid-shift or mid-dwell SHALL abandon the sequence; after release, DWELL_LO counting SHALL restart from zero.

Configuration
REQ-026 Macro PING_PONG_HI_DWELL_EN defined SHALL compile in DWELL_HI state and its dwell; undefined, DWELL_HI state SHALL be absent, SHIFT_UP SHALL go directly to SHIFT_DN, and DWELL_HI parameter SHALL be ignored.

Verification
REQ-027 WIDTH=8, DWELL_LO=3, no macro, en=1: edges 1-3 count=0x01, edge 4 0x02, edge 10 0x80, edge 11 0x40, edge 17 0x01, wrap high cycle after edge 17, edge 21 0x02.
REQ-028 Same with macro, DWELL_HI=2: edge 10 0x80, edges 11-12 hold 0x80 with dwell=1 dir=0, edge 13 0x40, edge 19 0x01.
REQ-029 DWELL_LO=0, WIDTH=4, no macro: count sequence 0x2,0x4,0x8,0x4,0x2,0x1,0x2 on edges 1-7; wrap after edge 6.
REQ-030 Toggle en low for 5 cycles mid-SHIFT_UP at 0x08: count, dir, dwell frozen at 0x08/1/0; sequence resumes unchanged.
REQ-031 Assert reset asynchronously mid-SHIFT_DN at 0x20: count=0x01, dir=1, dwell=1 before next clk edge; clr=1 at 0x10 gives same state on that edge.
